// File: rtl/register_trace_checker_pkg.sv
// checker_types: FSM state and compare-mode encodings shared by register_trace_checker.
package checker_types;
    typedef enum logic [1:0] {IDLE, DELAY, CHECK, DONE} state_e;
    localparam logic MODE_CYCLE  = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;
endpackage

// File: rtl/register_trace_checker_trace_memory.sv
// trace_memory: per-channel expected-value storage, one sync write port, combinational current/next reads.
module trace_memory #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock_i,
    input  logic                           we_i,
    input  logic [CH_W-1:0]                wr_ch_i,
    input  logic [INDEX_WIDTH-1:0]         wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [CHANNELS*INDEX_WIDTH-1:0] rd_idx_i,
    output logic [CHANNELS*DATA_WIDTH-1:0]  cur_data_o,
    output logic [CHANNELS*DATA_WIDTH-1:0]  nxt_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [CHANNELS][DEPTH];

    always_ff @(posedge clock_i) begin
        if (we_i) mem_q[wr_ch_i][wr_idx_i] <= wr_data_i;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_rd
        assign cur_data_o[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c][rd_idx_i[c*INDEX_WIDTH +: INDEX_WIDTH]];
        assign nxt_data_o[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c][rd_idx_i[c*INDEX_WIDTH +: INDEX_WIDTH] + INDEX_WIDTH'(1)];
    end
endmodule

// File: rtl/register_trace_checker.sv
// register_trace_checker: compares watched register values against stored traces,
// either strictly per cycle or on value change, and latches a pass/fail verdict.
module register_trace_checker
    import checker_types::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int WAIT_WIDTH  = 16,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           load_enable_i,
    input  logic [CH_W-1:0]                load_channel_i,
    input  logic [INDEX_WIDTH-1:0]         load_index_i,
    input  logic [DATA_WIDTH-1:0]          load_data_i,
    input  logic                           start_i,
    input  logic                           mode_i,
    input  logic [INDEX_WIDTH:0]           length_i,
    input  logic [WAIT_WIDTH-1:0]          start_delay_i,
    input  logic [WAIT_WIDTH-1:0]          timeout_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] watch_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           fail_o,
    output logic [CH_W-1:0]                fail_channel_o,
    output logic [INDEX_WIDTH-1:0]         fail_index_o,
    output logic [DATA_WIDTH-1:0]          fail_expected_o,
    output logic [DATA_WIDTH-1:0]          fail_actual_o,
    output logic                           timed_out_o
);
    state_e state_q;
    logic mode_q, busy_q, done_q, pass_q, fail_q, timed_out_q, timeout_hit;
    logic [INDEX_WIDTH:0] len_q, len_m1;
    logic [WAIT_WIDTH-1:0] cnt_q, timeout_q;
    logic [CHANNELS*INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [CH_W-1:0] fail_channel_q, mis_ch, open_ch;
    logic [INDEX_WIDTH-1:0] fail_index_q;
    logic [DATA_WIDTH-1:0] fail_expected_q, fail_actual_q;
    logic [CHANNELS*DATA_WIDTH-1:0] cur_flat, nxt_flat;
    logic [DATA_WIDTH-1:0] watch [CHANNELS], cur [CHANNELS], nxt [CHANNELS];
    logic [INDEX_WIDTH-1:0] idx [CHANNELS], idx_n [CHANNELS];
    logic [CHANNELS-1:0] last, adv, mis, fin;

    trace_memory #(
        .CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .INDEX_WIDTH(INDEX_WIDTH)
    ) u_mem (
        .clock_i    (clock_i),
        .we_i       (load_enable_i && !busy_q),
        .wr_ch_i    (load_channel_i),
        .wr_idx_i   (load_index_i),
        .wr_data_i  (load_data_i),
        .rd_idx_i   (idx_q),
        .cur_data_o (cur_flat),
        .nxt_data_o (nxt_flat)
    );

    assign len_m1      = len_q - (INDEX_WIDTH+1)'(1);
    assign timeout_hit = cnt_q + WAIT_WIDTH'(1) == timeout_q;

    // Per-channel compare: in on-change mode a channel may step to its next entry; mode 0 steps all together.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign watch[c] = watch_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        assign cur[c]   = cur_flat[c*DATA_WIDTH +: DATA_WIDTH];
        assign nxt[c]   = nxt_flat[c*DATA_WIDTH +: DATA_WIDTH];
        assign idx[c]   = idx_q[c*INDEX_WIDTH +: INDEX_WIDTH];
        assign last[c]  = {1'b0, idx[c]} == len_m1;
        assign adv[c]   = mode_q == MODE_CHANGE && watch[c] != cur[c] && !last[c] && watch[c] == nxt[c];
        assign mis[c]   = watch[c] != cur[c] && !adv[c];
        assign idx_n[c] = (mode_q == MODE_CYCLE || adv[c]) ? idx[c] + INDEX_WIDTH'(1) : idx[c];
        assign fin[c]   = {1'b0, idx_n[c]} == len_m1;
        assign idx_d[c*INDEX_WIDTH +: INDEX_WIDTH] = idx_n[c];
    end

    always_comb begin
        mis_ch  = '0;
        open_ch = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            mis_ch  = mis[c] ? CH_W'(c) : mis_ch;
            open_ch = fin[c] ? open_ch : CH_W'(c);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q         <= IDLE;
            mode_q          <= MODE_CYCLE;
            len_q           <= '0;
            cnt_q           <= '0;
            timeout_q       <= '0;
            idx_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            fail_channel_q  <= '0;
            fail_index_q    <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    mode_q          <= mode_i;
                    len_q           <= length_i;
                    cnt_q           <= start_delay_i;
                    timeout_q       <= timeout_i;
                    idx_q           <= '0;
                    fail_q          <= 1'b0;
                    timed_out_q     <= 1'b0;
                    fail_channel_q  <= '0;
                    fail_index_q    <= '0;
                    fail_expected_q <= '0;
                    fail_actual_q   <= '0;
                    busy_q          <= length_i != '0;
                    done_q          <= length_i == '0;
                    pass_q          <= length_i == '0;
                    state_q         <= length_i == '0 ? DONE : (start_delay_i == '0 ? CHECK : DELAY);
                end
                DELAY: begin
                    cnt_q   <= cnt_q == WAIT_WIDTH'(1) ? '0 : cnt_q - WAIT_WIDTH'(1);
                    state_q <= cnt_q == WAIT_WIDTH'(1) ? CHECK : DELAY;
                end
                CHECK: begin
                    cnt_q <= cnt_q + WAIT_WIDTH'(1);
                    idx_q <= idx_d;
                    if (|mis) begin
                        state_q         <= DONE;
                        busy_q          <= 1'b0;
                        done_q          <= 1'b1;
                        fail_q          <= 1'b1;
                        fail_channel_q  <= mis_ch;
                        fail_index_q    <= idx[mis_ch];
                        fail_expected_q <= (mode_q == MODE_CYCLE || last[mis_ch]) ? cur[mis_ch] : nxt[mis_ch];
                        fail_actual_q   <= watch[mis_ch];
                    end else if (mode_q == MODE_CYCLE ? last[0] : &fin) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (mode_q == MODE_CHANGE && timeout_hit) begin
                        state_q         <= DONE;
                        busy_q          <= 1'b0;
                        done_q          <= 1'b1;
                        fail_q          <= 1'b1;
                        timed_out_q     <= 1'b1;
                        fail_channel_q  <= open_ch;
                        fail_index_q    <= idx_n[open_ch];
                        fail_expected_q <= nxt[open_ch];
                        fail_actual_q   <= watch[open_ch];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign timed_out_o     = timed_out_q;
    assign fail_channel_o  = fail_channel_q;
    assign fail_index_o    = fail_index_q;
    assign fail_expected_o = fail_expected_q;
    assign fail_actual_o   = fail_actual_q;
endmodule
